// File: rtl/led_pkg.sv
// Shared constants and types for the on-board LED blocks.
package led_pkg;

    localparam logic [2:0] COLOR_OFF   = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_WHITE = 3'b111;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler; tick pulses for one clk each time the counter wraps to 0.
module led_tick_gen #(
    parameter int unsigned PRESCALE_BITS = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [PRESCALE_BITS-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + PRESCALE_BITS'(1);
            tick  <= &cnt_q;
        end
    end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin sharing of one RGB LED between NREQ requesters, with dwell time and blink.
// Optional PWM dimming via brightness input when RGB_LED_ARB_PWM_EN is defined.
module rgb_led_arbiter
    import led_pkg::*;
#(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned PRESCALE_BITS = 20,
    parameter int unsigned DWELL_TICKS   = 16,
    parameter int unsigned BLINK_TICKS   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef RGB_LED_ARB_PWM_EN
    input  logic [7:0]        brightness,
`endif
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_color,
    input  logic [NREQ-1:0]   req_blink,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned DW    = $clog2(DWELL_TICKS + 1);
    localparam int unsigned BW    = $clog2(BLINK_TICKS + 1);
    localparam logic [DW-1:0]    DWELL_LOAD = DW'(DWELL_TICKS);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NREQ - 1);

    arb_state_t       state_q;
    logic [NREQ-1:0]  grant_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [DW-1:0]    dwell_q;
    logic [BW-1:0]    blink_cnt_q;
    logic             phase_q;
    logic [2:0]       led_q;
    logic             tick;

    led_tick_gen #(
        .PRESCALE_BITS(PRESCALE_BITS)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    logic [IDX_W-1:0] owner_idx;
    logic [2:0]       owner_color;
    logic             owner_blink;
    logic             owner_req;

    always_comb begin
        owner_idx   = '0;
        owner_color = COLOR_OFF;
        owner_blink = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                owner_idx   = IDX_W'(i);
                owner_color = req_color[3*i +: 3];
                owner_blink = req_blink[i];
            end
        end
    end

    assign owner_req = |(req & grant_q);

    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] search_base;
    logic [IDX_W-1:0] idx;
    logic             win_found;
    logic [NREQ-1:0]  win_onehot;

    assign next_ptr    = (owner_idx == IDX_LAST) ? '0 : owner_idx + IDX_W'(1);
    assign search_base = (state_q == ARB_HOLD) ? next_ptr : rr_ptr_q;

    // First asserted request at or after search_base, wrapping.
    always_comb begin
        idx        = '0;
        win_found  = 1'b0;
        win_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDX_W'((int'(search_base) + k) % NREQ);
            if (!win_found && req[idx]) begin
                win_found       = 1'b1;
                win_onehot[idx] = 1'b1;
            end
        end
    end

    logic rearb;
    logic blink_restart;
    logic blink_step;
    logic pwm_on;

    assign rearb = (state_q == ARB_HOLD) && ((dwell_q == '0) || !owner_req);
    // A re-win by the sole current owner keeps the blink rhythm running.
    assign blink_restart = win_found && (((state_q == ARB_IDLE) && (req != '0)) ||
                                         (rearb && (win_onehot != grant_q)));
    assign blink_step    = (state_q == ARB_HOLD) && tick && !blink_restart;

`ifdef RGB_LED_ARB_PWM_EN
    logic [7:0] pwm_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end

    assign pwm_on = (pwm_cnt_q < brightness);
`else
    assign pwm_on = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            dwell_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            led_q       <= COLOR_OFF;
        end else begin
            if (state_q == ARB_IDLE) begin
                if (win_found) begin
                    state_q <= ARB_HOLD;
                    grant_q <= win_onehot;
                    dwell_q <= DWELL_LOAD;
                end
            end else if (rearb) begin
                rr_ptr_q <= next_ptr;
                if (win_found) begin
                    grant_q <= win_onehot;
                    dwell_q <= DWELL_LOAD;
                end else begin
                    grant_q <= '0;
                    state_q <= ARB_IDLE;
                end
            end else if (tick && (dwell_q != '0)) begin
                dwell_q <= dwell_q - DW'(1);
            end

            if (blink_restart) begin
                phase_q     <= 1'b1;
                blink_cnt_q <= '0;
            end else if (blink_step) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end

            led_q <= owner_color & {3{~owner_blink | phase_q}} & {3{pwm_on}};
        end
    end

    assign grant = grant_q;
    assign busy  = |grant_q;
    assign led_r = led_q[2];
    assign led_g = led_q[1];
    assign led_b = led_q[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Self-checking bench for rgb_led_arbiter with a fast prescaler and short dwell/blink.
module tb_rgb_led_arbiter;

    localparam int unsigned NREQ = 4;

    logic              clk;
    logic              rst_n;
    logic [7:0]        brightness;
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_color;
    logic [NREQ-1:0]   req_blink;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              led_r;
    logic              led_g;
    logic              led_b;
    logic [2:0]        led;

    int checks   = 0;
    int failures = 0;

    logic [3:0] gnt_exp_q[$];
    logic [2:0] led_exp_q[$];

    assign led = {led_r, led_g, led_b};

    rgb_led_arbiter #(
        .NREQ         (NREQ),
        .PRESCALE_BITS(2),
        .DWELL_TICKS  (3),
        .BLINK_TICKS  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RGB_LED_ARB_PWM_EN
        .brightness(brightness),
`endif
        .req       (req),
        .req_color (req_color),
        .req_blink (req_blink),
        .grant     (grant),
        .busy      (busy),
        .led_r     (led_r),
        .led_g     (led_g),
        .led_b     (led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n     = 1'b0;
        req       = '0;
        req_color = '0;
        req_blink = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req       = 4'b1111;
        req_color = 12'hFFF;
        req_blink = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL reset_grant got=%b want=0000", grant);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (led !== 3'b000) begin
            failures++;
            $display("FAIL reset_led got=%b want=000", led);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL first_grant got=%b want=0001", grant);
        end
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || led !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got grant=%b led=%b want 0000/000", grant, led);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL restart_grant got=%b want=0001", grant);
        end
    endtask

    task automatic test_single;
        logic held;
        do_reset();
        req_color[8:6] = 3'b101;
        req            = 4'b0100;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got=%b busy=%b want=0100 busy=1", grant, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (led !== 3'b101) begin
            failures++;
            $display("FAIL single_led got=%b want=101", led);
        end
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (grant !== 4'b0100) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            failures++;
            $display("FAIL single_hold got=%b want=1 (grant kept across dwell expiry)", held);
        end
        req_color[8:6] = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (led !== 3'b010) begin
            failures++;
            $display("FAIL live_color got=%b want=010", led);
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] prev;
        logic [3:0] exp_g;
        logic       gap;
        int         last_change;
        int         dur;
        do_reset();
        gnt_exp_q.push_back(4'b0001);
        gnt_exp_q.push_back(4'b0010);
        gnt_exp_q.push_back(4'b0100);
        gnt_exp_q.push_back(4'b1000);
        gnt_exp_q.push_back(4'b0001);
        req         = 4'b1111;
        prev        = 4'b0000;
        gap         = 1'b0;
        last_change = 0;
        for (int cyc = 1; cyc <= 200 && gnt_exp_q.size() > 0; cyc++) begin
            @(posedge clk);
            #1;
            if (prev != 4'b0000 && grant === 4'b0000) gap = 1'b1;
            if (grant !== prev) begin
                exp_g = gnt_exp_q.pop_front();
                checks++;
                if (grant !== exp_g) begin
                    failures++;
                    $display("FAIL rr_order got=%b want=%b", grant, exp_g);
                end
                if (prev != 4'b0000) begin
                    dur = cyc - last_change;
                    checks++;
                    if (dur < 10 || dur > 13) begin
                        failures++;
                        $display("FAIL rr_dwell got=%0d clk want=10..13", dur);
                    end
                end
                prev        = grant;
                last_change = cyc;
            end
        end
        checks++;
        if (gnt_exp_q.size() != 0) begin
            failures++;
            $display("FAIL rr_timeout got=%0d pending want=0", gnt_exp_q.size());
            gnt_exp_q.delete();
        end
        checks++;
        if (gap !== 1'b0) begin
            failures++;
            $display("FAIL rr_no_gap got=%b want=0", gap);
        end
    endtask

    task automatic test_early_release;
        do_reset();
        req_color[11:9] = 3'b011;
        req             = 4'b0001;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL early_first got=%b want=0001", grant);
        end
        repeat (2) @(posedge clk);
        #1;
        req = 4'b1000;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b1000) begin
            failures++;
            $display("FAIL early_handover got=%b want=1000", grant);
        end
        req = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL early_idle got=%b busy=%b want=0000 busy=0", grant, busy);
        end
        checks++;
        if (led !== 3'b011) begin
            failures++;
            $display("FAIL early_led_last got=%b want=011", led);
        end
        @(posedge clk);
        #1;
        checks++;
        if (led !== 3'b000) begin
            failures++;
            $display("FAIL early_led_off got=%b want=000", led);
        end
    endtask

    task automatic test_blink;
        logic [2:0] prev;
        logic [2:0] exp_l;
        int         n_change;
        int         last_change;
        logic       seen_off;
        do_reset();
        led_exp_q.push_back(3'b111);
        led_exp_q.push_back(3'b000);
        led_exp_q.push_back(3'b111);
        led_exp_q.push_back(3'b000);
        led_exp_q.push_back(3'b111);
        req_color[2:0] = 3'b111;
        req_blink[0]   = 1'b1;
        req            = 4'b0001;
        prev           = 3'b000;
        n_change       = 0;
        last_change    = 0;
        for (int cyc = 1; cyc <= 150 && led_exp_q.size() > 0; cyc++) begin
            @(posedge clk);
            #1;
            if (led !== prev) begin
                n_change++;
                exp_l = led_exp_q.pop_front();
                checks++;
                if (led !== exp_l) begin
                    failures++;
                    $display("FAIL blink_value got=%b want=%b", led, exp_l);
                end
                if (n_change >= 3) begin
                    checks++;
                    if (cyc - last_change != 8) begin
                        failures++;
                        $display("FAIL blink_period got=%0d clk want=8", cyc - last_change);
                    end
                end
                prev        = led;
                last_change = cyc;
            end
        end
        checks++;
        if (led_exp_q.size() != 0) begin
            failures++;
            $display("FAIL blink_timeout got=%0d pending want=0", led_exp_q.size());
            led_exp_q.delete();
        end
        seen_off = 1'b0;
        for (int i = 0; i < 20 && !seen_off; i++) begin
            @(posedge clk);
            #1;
            if (led === 3'b000) seen_off = 1'b1;
        end
        checks++;
        if (seen_off !== 1'b1) begin
            failures++;
            $display("FAIL blink_off_wait got=%b want=1", seen_off);
        end
        req_color[5:3] = 3'b111;
        req_blink[1]   = 1'b1;
        req            = 4'b0010;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL blink_new_grant got=%b want=0010", grant);
        end
        @(posedge clk);
        #1;
        checks++;
        if (led !== 3'b111) begin
            failures++;
            $display("FAIL blink_phase_restart got=%b want=111", led);
        end
    endtask

`ifdef RGB_LED_ARB_PWM_EN
    task automatic test_pwm;
        int on_cnt;
        do_reset();
        req_color[2:0] = 3'b111;
        req            = 4'b0001;
        brightness     = 8'd64;
        repeat (3) @(posedge clk);
        #1;
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            if (led_r === 1'b1) on_cnt++;
        end
        checks++;
        if (on_cnt != 64) begin
            failures++;
            $display("FAIL pwm_64 got=%0d want=64", on_cnt);
        end
        brightness = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            if (led !== 3'b000) on_cnt++;
        end
        checks++;
        if (on_cnt != 0) begin
            failures++;
            $display("FAIL pwm_0 got=%0d want=0", on_cnt);
        end
        brightness = 8'd255;
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        brightness = 8'd255;
        req        = '0;
        req_color  = '0;
        req_blink  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_blink();
`ifdef RGB_LED_ARB_PWM_EN
        test_pwm();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
